team_06_i2s_capture_ctrl: RTL
=============================

Name: team_06_i2s_capture_ctrl

Overview:
Master-mode I2S capture controller for the team_06 ADC input path. Generates the bit clock (i2sclk) and word select (ws) toward the ADC, and sequences bit-by-bit sampling of adc_serial_in into MSB-first words, one per channel slot. Completed samples are buffered in a small FIFO and handed to the downstream audio datapath over a valid/ready handshake. Start/stop is frame-aligned.

Parameters:
CLK_DIV, 4, clk cycles per i2sclk half-period; legal range 2 or more.
SLOT_BITS, 32, i2sclk cycles per ws half (one channel slot).
SAMPLE_BITS, 8, MSB-first bits captured per slot; SAMPLE_BITS+1 <= SLOT_BITS.
FIFO_DEPTH, 4, sample buffer entries; power of 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  capture enable, sampled on clk
adc_serial_in  in  1  serial data from ADC, MSB first
i2sclk  out  1  generated bit clock to ADC
ws  out  1  word select: 0 = left slot, 1 = right slot
sample_data  out  SAMPLE_BITS  FIFO head sample
sample_right  out  1  FIFO head channel tag: 1 = right
sample_valid  out  1  FIFO non-empty
sample_ready  in  1  consumer accepts head this cycle
overflow  out  1  sticky: a sample was dropped
clr_overflow  in  1  clears overflow
busy  out  1  controller in RUN state

Behaviour:
- Reset (async, immediate) and power-up values:
  - i2sclk=0, ws=0, busy=0.
  - sample_valid=0, sample_data=0, sample_right=0, overflow=0.
  - FIFO empty; all counters 0; state IDLE.
- States: IDLE, RUN.
  - IDLE->RUN when en=1. Counters start from 0; i2sclk=0, ws=0.
  - RUN->IDLE only at a frame boundary: the falling i2sclk edge that ends bit SLOT_BITS-1 of the right slot (ws=1) while en=0. At that point i2sclk=0, ws=0, counters clear.
  - en=0 mid-frame does not stop capture; the rest of the frame, including the right sample, completes.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 in RUN. On wrap, i2sclk toggles.
  - i2sclk period is 2*CLK_DIV clks; the first edge after entering RUN is rising, CLK_DIV clks later.
- Bit position:
  - bit_cnt (0..SLOT_BITS-1) is the position within the current slot and advances on each i2sclk falling edge.
  - On the falling edge ending position SLOT_BITS-1: ws toggles and bit_cnt returns to 0.
- Sampling, standard I2S with 1-bit delay:
  - adc_serial_in is sampled in the clk cycle where i2sclk goes 0->1.
  - Position 0 is the delay bit and is ignored.
  - Positions 1..SAMPLE_BITS are shifted left into the word (MSB first).
  - Positions above SAMPLE_BITS are ignored.
- Push:
  - After the rising edge at position SAMPLE_BITS, {ws, word} is pushed in the next clk cycle.
  - sample_valid rises one clk after the push when the FIFO was empty.
  - A word with all positions driven 0 still pushes 0x00.
- FIFO:
  - First-word-fall-through: sample_data and sample_right show the head whenever sample_valid=1.
  - Pop on sample_valid & sample_ready.
  - Push to a full FIFO with no simultaneous pop: the new sample is dropped, the stored contents are unchanged, and overflow is set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pop when empty: no effect.
- overflow: sticky; clr_overflow clears it. If a set and a clear occur in the same cycle, set wins.
- Arithmetic: FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty. bit_cnt and div_cnt must never exceed their maximum values.
- Reset mid-operation: the in-progress word is discarded, the FIFO is flushed and outputs return to reset values immediately. The block restarts from IDLE.

Test Plan:
1. Assert rst, then release with en=0 for 50 clks -> all outputs 0, i2sclk static 0, busy=0.
2. en=1, ADC model drives 10100111 on positions 1..8 of the left slot and 01011100 in the right slot -> sample 0xA7 right=0, then 0x5C right=1. First i2sclk rise occurs 4 clks after busy rises; ws toggles every 256 clks.
3. Consecutive frames carrying 0xFF (L), 0x80 (R), 0x7F (L) -> exact values and tags popped in order. Delay-bit and post-LSB positions driven to the opposite value do not corrupt the samples.
4. sample_ready=0 across 5 captured words with FIFO_DEPTH=4 -> the first 4 are held in order, the 5th is dropped and overflow=1. Draining yields the 4 originals. clr_overflow -> overflow=0. A full-FIFO push coinciding with a pop -> no overflow.
5. Drop en midway through a left slot -> both the left and right samples of that frame are delivered, then busy=0, i2sclk=0, ws=0 with no further edges. Re-assert en -> capture resumes cleanly.
6. Pulse rst mid-word with 2 samples queued -> sample_valid=0 and overflow=0 immediately. After release with en=1, the next sample equals the newly driven word.

Source files
------------

// File: rtl/team_06_i2s_capture_ctrl.sv
// Master-mode I2S capture controller: generates i2sclk/ws, deserialises MSB-first slot words
// with the standard one-bit delay, and buffers {channel, sample} in a first-word-fall-through FIFO.
module team_06_i2s_capture_ctrl #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned SAMPLE_BITS = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   adc_serial_in,
  output logic                   i2sclk,
  output logic                   ws,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_right,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic                   busy
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EntW = SAMPLE_BITS + 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic                   i2sclk_q, i2sclk_d;
  logic                   ws_q, ws_d;
  logic [SAMPLE_BITS-1:0] word_q, word_d;
  logic                   push_q, push_d;
  logic [PtrW:0]          wr_ptr_q, rd_ptr_q;
  logic                   overflow_q, overflow_d;
  logic [EntW-1:0]        mem [FIFO_DEPTH];

  logic div_wrap, rise, fall, slot_end, frame_end;
  logic empty, full, pop, do_push;
  logic [EntW-1:0] head;

  assign div_wrap  = (state_q == StRun) && (div_q == DivW'(CLK_DIV - 1));
  assign rise      = div_wrap && !i2sclk_q;
  assign fall      = div_wrap && i2sclk_q;
  assign slot_end  = fall && (bit_q == BitW'(SLOT_BITS - 1));
  assign frame_end = slot_end && ws_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    i2sclk_d = i2sclk_q;
    ws_d     = ws_q;
    word_d   = word_q;
    push_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StRun;
      end
      StRun: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) i2sclk_d = ~i2sclk_q;
        // Position 0 is the I2S delay bit; only positions 1..SAMPLE_BITS carry data.
        if (rise && (bit_q != '0) && (bit_q <= BitW'(SAMPLE_BITS))) begin
          word_d = {word_q[SAMPLE_BITS-2:0], adc_serial_in};
        end
        if (rise && (bit_q == BitW'(SAMPLE_BITS))) push_d = 1'b1;
        if (fall) begin
          if (slot_end) begin
            bit_d = '0;
            ws_d  = ~ws_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        if (frame_end && !en) begin
          state_d  = StIdle;
          div_d    = '0;
          bit_d    = '0;
          i2sclk_d = 1'b0;
          ws_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      i2sclk_q <= 1'b0;
      ws_q     <= 1'b0;
      word_q   <= '0;
      push_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      i2sclk_q <= i2sclk_d;
      ws_q     <= ws_d;
      word_q   <= word_d;
      push_q   <= push_d;
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop     = !empty && sample_ready;
  assign do_push = push_q && (!full || pop);
  assign overflow_d = (push_q && full && !pop) || (overflow_q && !clr_overflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[PtrW-1:0]] <= {ws_q, word_q};
  end

  assign head = mem[rd_ptr_q[PtrW-1:0]];

  // Head is masked while empty so stale storage never reaches the outputs.
  assign sample_valid = !empty;
  assign sample_data  = sample_valid ? head[SAMPLE_BITS-1:0] : '0;
  assign sample_right = sample_valid ? head[SAMPLE_BITS] : 1'b0;
  assign overflow     = overflow_q;
  assign i2sclk       = i2sclk_q;
  assign ws           = ws_q;
  assign busy         = (state_q == StRun);

endmodule
